io_ram_arbiter: RTL and testbench
=================================

IO_RAM_ARBITER -- requirements
Module: io_ram_arbiter

Interface
REQ-001 Parameters SHALL be:
- RD_LATENCY, default 1, cycles from a granted read to valid ram_rd.
- MAX_BURST, default 8, consecutive grants one master may hold while the other requests.
REQ-002 Ports SHALL be as follows (N = 0, 1; master 0 = CPU data port, master 1 = UART loader):
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- mN_req  in  1  master N requests one access
- mN_addr  in  32  byte address
- mN_wd  in  32  write data
- mN_we  in  1  1 = write, 0 = read
- mN_ctrl  in  2  access size: 00 word, 01 half, 10 byte
- mN_gnt  out  1  access accepted this cycle
- mN_rvalid  out  1  read data valid
- mN_rdata  out  32  read data
- address  out  32  to io_ram_datapath
- wd  out  32  to io_ram_datapath
- we  out  1  to io_ram_datapath
- mem_ctrl  out  2  to io_ram_datapath
- rd  in  32  read data from io_ram_datapath

Function
REQ-003 FSM states SHALL be IDLE, OWN0 and OWN1, held in a registered state; register `last` SHALL hold the most recent owner.
REQ-004 From IDLE:
- only mN_req set -> OWNN;
- both set -> the master not equal to `last`;
- neither set -> stay in IDLE.
REQ-005 In OWNN:
- mN_gnt = mN_req, combinationally;
- address, wd, mem_ctrl SHALL carry master N's inputs;
- we = mN_we & mN_gnt.
REQ-006 In IDLE, or whenever no grant is active, address, wd, mem_ctrl and we SHALL all be 0.
REQ-007 An access accepted in OWNN SHALL make burst_cnt increment, saturating at MAX_BURST; burst_cnt SHALL clear on every owner change or entry to IDLE.
REQ-008 Leaving OWNN:
- mN_req low and the other master requesting -> other owner;
- mN_req low and neither requesting -> IDLE;
- burst_cnt == MAX_BURST-1 on an accepted access while the other master requests -> other owner next cycle;
- otherwise stay in OWNN.
REQ-009 A granted read SHALL produce mN_rvalid exactly RD_LATENCY cycles later, with mN_rdata = rd captured in that cycle, routed by the master id tagged at grant time.
REQ-010 A granted write SHALL never produce rvalid.
REQ-011 Read returns SHALL keep their order and stay correct across an owner change, including back-to-back reads by alternating masters.
REQ-012 m0_gnt and m1_gnt SHALL never both be 1; at most one mN_rvalid SHALL be 1 per cycle.
REQ-013 Request-to-grant latency SHALL be 1 cycle from IDLE and 0 cycles while the requester already owns the port.
REQ-014 mN_rdata SHALL hold its last value while mN_rvalid is 0.

Reset
REQ-015 While rst_n = 0, asynchronously, independent of clk:
- state = IDLE, last = 1, burst_cnt = 0;
- read pipe cleared;
- all gnt, rvalid, rdata, address, wd, we, mem_ctrl outputs = 0.
REQ-016 Reset asserted mid-access SHALL drop the access: we SHALL fall immediately and no rvalid SHALL follow after release.
REQ-017 After rst_n rises, the first tie SHALL go to master 0.

Structure
REQ-018 Shared package io_ram_pkg SHALL hold:
- the state enum;
- MEM_CTRL encodings (WORD 00, HALF 01, BYTE 10);
- the master-id type.
REQ-019 Sub-module io_ram_rd_pipe SHALL implement the RD_LATENCY-deep shift register of {valid, master id}; the arbitration FSM SHALL stay in io_ram_arbiter.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- m0 read addr 0x4 (rd = 0x11223344) -> m0_gnt 1 cycle after req; m0_rvalid 1 cycle after gnt with m0_rdata = 0x11223344; m1 outputs idle.
- m0 and m1 request from IDLE after reset -> m0 granted first; m1 granted when m0_req drops.
- m0 holds req for 12 cycles while m1 holds req -> m0 gets exactly 8 grants, then m1 is granted.
- m1 write addr 0x10, wd 0xDEADBEEF, ctrl 10 -> we = 1 for one cycle with address 0x10, wd 0xDEADBEEF, mem_ctrl 10; no m1_rvalid.
- Alternating m0 read 0x0, m1 read 0x8 across an owner change -> each rvalid goes to the correct master with the correct data, in order.
- rst_n low during a granted write -> we = 0 within the same cycle; no rvalid after release; state = IDLE.

Source files
------------

// File: rtl/io_ram_pkg.sv
// Shared types for the io_ram arbiter slice: FSM states, access-size codes, master ids.
// Pure declarations; no timing or backpressure of its own.
package io_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10
  } mem_ctrl_t;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wd;
    logic        we;
    logic [1:0]  mem_ctrl;
  } mem_req_t;

endpackage

// File: rtl/io_ram_arbiter_if.sv
// Bus bundle between the two io_ram masters, the arbiter and the io_ram datapath.
// slave = arbiter side; master = the requesters plus the datapath read return.
interface io_ram_arbiter_if;

  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wd;
  logic        m0_we;
  logic [1:0]  m0_ctrl;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wd;
  logic        m1_we;
  logic [1:0]  m1_ctrl;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] address;
  logic [31:0] wd;
  logic        we;
  logic [1:0]  mem_ctrl;
  logic [31:0] rd;

  modport slave (
    input  m0_req, m0_addr, m0_wd, m0_we, m0_ctrl,
    input  m1_req, m1_addr, m1_wd, m1_we, m1_ctrl,
    input  rd,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output address, wd, we, mem_ctrl
  );

  modport master (
    output m0_req, m0_addr, m0_wd, m0_we, m0_ctrl,
    output m1_req, m1_addr, m1_wd, m1_we, m1_ctrl,
    output rd,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  address, wd, we, mem_ctrl
  );

endinterface

// File: rtl/io_ram_rd_pipe.sv
// Tags each granted read with its master id and delays {valid, id} by RD_LATENCY cycles.
// Fixed latency, no backpressure: the datapath always returns read data on time.
module io_ram_rd_pipe
  import io_ram_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vld,
  input  master_id_t in_id,
  output logic       out_vld,
  output master_id_t out_id
);

  logic [RD_LATENCY-1:0]       vld_q;
  master_id_t [RD_LATENCY-1:0] id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= in_vld;
      id_q[0]  <= in_id;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[RD_LATENCY-1];
  assign out_id  = id_q[RD_LATENCY-1];

endmodule

// File: rtl/io_ram_arbiter.sv
// Two-master arbiter (CPU data port, UART loader) onto one io_ram port, with burst-limited fairness.
// Grant 1 cycle from IDLE, 0 while owning; read data returns RD_LATENCY cycles after grant.
module io_ram_arbiter
  import io_ram_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 8
) (
  input logic              clk,
  input logic              rst_n,
  io_ram_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  master_id_t       last_q, last_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             gnt0, gnt1, at_limit;
  mem_req_t         sel;
  logic             rd_push, pipe_vld;
  master_id_t       pipe_id;
  logic             rvalid0, rvalid1;
  logic [31:0]      rdata0_q, rdata1_q;

  assign gnt0     = (state_q == OWN0) && bus.m0_req;
  assign gnt1     = (state_q == OWN1) && bus.m1_req;
  // >= rather than == so a burst that saturated while the other side was quiet still yields.
  assign at_limit = burst_q >= CNT_W'(MAX_BURST - 1);

  always_comb begin
    sel = '0;
    if (gnt0) begin
      sel = '{address: bus.m0_addr, wd: bus.m0_wd, we: bus.m0_we, mem_ctrl: bus.m0_ctrl};
    end else if (gnt1) begin
      sel = '{address: bus.m1_addr, wd: bus.m1_wd, we: bus.m1_we, mem_ctrl: bus.m1_ctrl};
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) state_d = (last_q == M0) ? OWN1 : OWN0;
        else if (bus.m0_req)          state_d = OWN0;
        else if (bus.m1_req)          state_d = OWN1;
      end
      OWN0: begin
        if (!bus.m0_req)                 state_d = bus.m1_req ? OWN1 : IDLE;
        else if (bus.m1_req && at_limit) state_d = OWN1;
      end
      OWN1: begin
        if (!bus.m1_req)                 state_d = bus.m0_req ? OWN0 : IDLE;
        else if (bus.m0_req && at_limit) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == OWN0) last_d = M0;
    else if (state_d == OWN1) last_d = M1;

    if (state_d != state_q) burst_d = '0;
    else if ((gnt0 || gnt1) && (burst_q < CNT_W'(MAX_BURST))) burst_d = burst_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= M1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  assign rd_push = (gnt0 && !bus.m0_we) || (gnt1 && !bus.m1_we);

  io_ram_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (rd_push),
    .in_id  (gnt1 ? M1 : M0),
    .out_vld(pipe_vld),
    .out_id (pipe_id)
  );

  assign rvalid0 = pipe_vld && (pipe_id == M0);
  assign rvalid1 = pipe_vld && (pipe_id == M1);

  // rd is live in the return cycle; the holding registers keep it visible afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= bus.rd;
      if (rvalid1) rdata1_q <= bus.rd;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.m0_rdata  = rvalid0 ? bus.rd : rdata0_q;
  assign bus.m1_rdata  = rvalid1 ? bus.rd : rdata1_q;
  assign bus.address   = sel.address;
  assign bus.wd        = sel.wd;
  assign bus.we        = sel.we;
  assign bus.mem_ctrl  = sel.mem_ctrl;

endmodule

// File: tb/tb_io_ram_arbiter.sv
// Directed bench for io_ram_arbiter: drive just after rising edges, sample on falling edges.
// Read data is driven by hand in the cycle each return is expected.
module tb_io_ram_arbiter;
  import io_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  io_ram_arbiter_if bus ();

  io_ram_arbiter #(.RD_LATENCY(1), .MAX_BURST(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_wd = '0; bus.m0_we = 1'b0; bus.m0_ctrl = '0;
    bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_wd = '0; bus.m1_we = 1'b0; bus.m1_ctrl = '0;
    bus.rd = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_m0(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [1:0] c);
    bus.m0_req = 1'b1; bus.m0_addr = a; bus.m0_wd = d; bus.m0_we = w; bus.m0_ctrl = c;
  endtask

  task automatic drive_m1(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [1:0] c);
    bus.m1_req = 1'b1; bus.m1_addr = a; bus.m1_wd = d; bus.m1_we = w; bus.m1_ctrl = c;
  endtask

  int g0, g1, both, first_m1, rv_cnt;

  initial begin
    // Reset with requests asserted: everything must stay quiet.
    idle_all();
    rst_n = 1'b0;
    drive_m0(32'h40, 32'h1, 1'b1, MEM_WORD);
    drive_m1(32'h44, 32'h2, 1'b1, MEM_WORD);
    mid();
    check("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    check("rst_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_address", bus.address, 32'h0);
    check("rst_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'd0);
    check("rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'h0);
    idle_all();
    tick();
    rst_n = 1'b1;

    // Single m0 read of 0x4.
    drive_m0(32'h4, 32'h0, 1'b0, MEM_WORD);
    mid();
    check("s1_gnt_wait", 32'(bus.m0_gnt), 32'd0);
    tick();
    mid();
    check("s1_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    check("s1_address", bus.address, 32'h4);
    check("s1_we", 32'(bus.we), 32'd0);
    check("s1_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    tick();
    bus.m0_req = 1'b0;
    bus.rd = 32'h1122_3344;
    mid();
    check("s1_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    check("s1_m0_rdata", bus.m0_rdata, 32'h1122_3344);
    check("s1_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    check("s1_m1_rdata", bus.m1_rdata, 32'h0);
    check("s1_addr_nogrant", bus.address, 32'h0);
    tick();
    bus.rd = 32'hFFFF_FFFF;
    mid();
    check("s1_rvalid_drop", 32'(bus.m0_rvalid), 32'd0);
    check("s1_rdata_hold", bus.m0_rdata, 32'h1122_3344);
    tick();

    // Tie from IDLE right after reset goes to m0.
    do_reset();
    drive_m0(32'h20, 32'h0, 1'b0, MEM_WORD);
    drive_m1(32'h24, 32'h0, 1'b0, MEM_WORD);
    mid();
    check("s2_idle_nogrant", 32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
    tick();
    mid();
    check("s2_m0_first", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b10);
    check("s2_address", bus.address, 32'h20);
    tick();
    bus.m0_req = 1'b0;
    mid();
    check("s2_handover_gap", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b00);
    tick();
    mid();
    check("s2_m1_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b01);
    check("s2_m1_address", bus.address, 32'h24);
    tick();
    idle_all();
    mid();
    check("s2_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    tick();

    // Burst limit: both hold reads for 12 cycles; m0 gets 8, then back-to-back m1 read.
    do_reset();
    drive_m0(32'h0, 32'h0, 1'b0, MEM_WORD);
    drive_m1(32'h8, 32'h0, 1'b0, MEM_WORD);
    g0 = 0; g1 = 0; both = 0; first_m1 = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.rd = 32'hA000_0000 + 32'(cyc);
      mid();
      if (bus.m0_gnt) g0++;
      if (bus.m1_gnt) begin
        g1++;
        if (first_m1 < 0) first_m1 = cyc;
      end
      if (bus.m0_gnt && bus.m1_gnt) both++;
      if (cyc == 9) begin
        check("s3_m0_last_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'b10);
        check("s3_m0_last_rdata", bus.m0_rdata, 32'hA000_0009);
      end
      if (cyc == 10) begin
        check("s3_m1_first_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'b01);
        check("s3_m1_first_rdata", bus.m1_rdata, 32'hA000_000A);
        check("s3_m0_rdata_hold", bus.m0_rdata, 32'hA000_0009);
      end
      tick();
    end
    check("s3_m0_grants", 32'(g0), 32'd8);
    check("s3_m1_grants", 32'(g1), 32'd3);
    check("s3_first_m1", 32'(first_m1), 32'd9);
    check("s3_both_gnt", 32'(both), 32'd0);
    idle_all();
    tick();

    // m1 byte write.
    drive_m1(32'h10, 32'hDEAD_BEEF, 1'b1, MEM_BYTE);
    mid();
    check("s4_we_wait", 32'(bus.we), 32'd0);
    tick();
    mid();
    check("s4_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    check("s4_we", 32'(bus.we), 32'd1);
    check("s4_address", bus.address, 32'h10);
    check("s4_wd", bus.wd, 32'hDEAD_BEEF);
    check("s4_mem_ctrl", 32'(bus.mem_ctrl), 32'(MEM_BYTE));
    tick();
    idle_all();
    mid();
    check("s4_we_off", 32'(bus.we), 32'd0);
    check("s4_no_rvalid", 32'(bus.m1_rvalid), 32'd0);
    tick();

    // Alternating reads m0 0x0 then m1 0x8 across an owner change.
    drive_m0(32'h0, 32'h0, 1'b0, MEM_WORD);
    drive_m1(32'h8, 32'h0, 1'b0, MEM_WORD);
    tick();
    mid();
    check("s5_m0_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b10);
    check("s5_m0_address", bus.address, 32'h0);
    tick();
    bus.m0_req = 1'b0;
    bus.rd = 32'hCAFE_0000;
    mid();
    check("s5_m0_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'b10);
    check("s5_m0_rdata", bus.m0_rdata, 32'hCAFE_0000);
    tick();
    bus.rd = 32'h0;
    mid();
    check("s5_m1_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b01);
    check("s5_m1_address", bus.address, 32'h8);
    tick();
    bus.m1_req = 1'b0;
    bus.rd = 32'h0BAD_F00D;
    mid();
    check("s5_m1_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'b01);
    check("s5_m1_rdata", bus.m1_rdata, 32'h0BAD_F00D);
    check("s5_m0_rdata_hold", bus.m0_rdata, 32'hCAFE_0000);
    tick();
    bus.rd = 32'h0;

    // Reset asserted mid-cycle during a granted write.
    drive_m0(32'h30, 32'h1234_5678, 1'b1, MEM_WORD);
    tick();
    mid();
    check("s6_we_before", 32'(bus.we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_we_async", 32'(bus.we), 32'd0);
    check("s6_gnt_async", 32'(bus.m0_gnt), 32'd0);
    check("s6_addr_async", bus.address, 32'h0);
    check("s6_rdata_async", bus.m0_rdata, 32'h0);
    tick();
    idle_all();
    tick();
    rst_n = 1'b1;
    rv_cnt = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      mid();
      if (bus.m0_rvalid || bus.m1_rvalid) rv_cnt++;
      tick();
    end
    check("s6_no_rvalid", 32'(rv_cnt), 32'd0);
    check("s6_state", 32'(dut.state_q), 32'(IDLE));
    drive_m1(32'h50, 32'h0, 1'b0, MEM_WORD);
    mid();
    check("s6_m1_wait", 32'(bus.m1_gnt), 32'd0);
    tick();
    mid();
    check("s6_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    tick();
    idle_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
